// File: rtl/avli2c_pkg.sv
// Shared types and helpers for the Avalon/I2C EEPROM interface buffers.
package avli2c_pkg;

    localparam int AVLI2C_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2
    } rdbuf_state_t;

    // Requested byte count is 1..4; anything outside that range means a full word.
    function automatic logic [2:0] clamp_length(input logic [2:0] length);
        if (length >= 3'd1 && length <= 3'd4) begin
            return length;
        end
        return 3'd4;
    endfunction

endpackage

// File: rtl/avli2c_read_data_buffer.sv
// Packs I2C read bytes little-endian into a 32-bit word; byte visible one edge after its strobe.
// No stall on the I2C side: bytes arriving outside COLLECT are dropped and flagged in overflow_o.
module avli2c_read_data_buffer
    import avli2c_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [2:0]  length_i,
    input  logic        clear_i,
    input  logic [7:0]  i2c_data_i,
    input  logic        i2c_data_valid_i,
    output logic        i2c_ready_o,
    output logic [31:0] data_o,
    output logic [3:0]  byte_valid_o,
    output logic        data_ready_o,
    input  logic        read_ack_i,
    output logic        overflow_o
);

    rdbuf_state_t state, state_n;
    logic [2:0]   count, count_n;
    logic [2:0]   target, target_n;
    logic [31:0]  data_buf, data_buf_n;
    logic [3:0]   byte_valid, byte_valid_n;
    logic         overflow, overflow_n;
    logic [1:0]   lane;

    assign lane = count[1:0];

    always_comb begin
        state_n      = state;
        count_n      = count;
        target_n     = target;
        data_buf_n   = data_buf;
        byte_valid_n = byte_valid;
        overflow_n   = overflow;

        if (clear_i) begin
            state_n      = IDLE;
            count_n      = 3'd0;
            target_n     = 3'd4;
            data_buf_n   = 32'd0;
            byte_valid_n = 4'd0;
            overflow_n   = 1'b0;
        end else if (start_i) begin
            // A coincident byte strobe is intentionally dropped without flagging overflow.
            state_n      = COLLECT;
            count_n      = 3'd0;
            target_n     = clamp_length(length_i);
            data_buf_n   = 32'd0;
            byte_valid_n = 4'd0;
            overflow_n   = 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (i2c_data_valid_i) begin
                        data_buf_n[{lane, 3'b000} +: 8] = i2c_data_i;
                        byte_valid_n[lane]              = 1'b1;
                        count_n                         = count + 3'd1;
                        if (count + 3'd1 == target) begin
                            state_n = READY;
                        end
                    end
                end
                READY: begin
                    if (i2c_data_valid_i) begin
                        overflow_n = 1'b1;
                    end
                    if (read_ack_i) begin
                        state_n      = IDLE;
                        data_buf_n   = 32'd0;
                        byte_valid_n = 4'd0;
                    end
                end
                default: begin
                    if (i2c_data_valid_i) begin
                        overflow_n = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state      <= IDLE;
            count      <= 3'd0;
            target     <= 3'd4;
            data_buf   <= 32'd0;
            byte_valid <= 4'd0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            target     <= target_n;
            data_buf   <= data_buf_n;
            byte_valid <= byte_valid_n;
            overflow   <= overflow_n;
        end
    end

    assign data_o       = data_buf;
    assign byte_valid_o = byte_valid;
    assign overflow_o   = overflow;
    assign i2c_ready_o  = (state == COLLECT);
    assign data_ready_o = (state == READY);

endmodule
